// File: rtl/ads8685_pkg.sv
// Shared constants and types for the ADS8685 SPI responder.
package ads8685_pkg;

  localparam int FRAME_BITS = 32;

  // Command opcodes carried in frame bits [31:25]
  localparam logic [6:0] OP_WR_HW = 7'b1101000;
  localparam logic [6:0] OP_RD_HW = 7'b1100100;
  localparam logic [6:0] OP_RD_B  = 7'b0100100;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  // Implemented configuration registers
  localparam logic [8:0] ADDR_SDI_CTL = 9'h00C;
  localparam logic [8:0] ADDR_SDO_CTL = 9'h010;
  localparam logic [8:0] ADDR_RANGE   = 9'h014;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [8:0]  addr;
    logic [15:0] data;
  } frame_t;

endpackage

// File: rtl/ads8685_if.sv
// ADC serial bus between the ADC controller (master) and the emulator (slave).
interface ads8685_if;
  logic convst_csn;
  logic ads_sclk;
  logic ads_sdi;
  logic ads_sdo0;
  logic ads_rvs;

  modport master (
    output convst_csn, ads_sclk, ads_sdi,
    input  ads_sdo0, ads_rvs
  );

  modport slave (
    input  convst_csn, ads_sclk, ads_sdi,
    output ads_sdo0, ads_rvs
  );
endinterface

// File: rtl/ads_sync_edge.sv
// N-stage synchronizer with single-cycle rise/fall strobes on the synced level.
module ads_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the synchronizer and keep the previous synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/ads8685_emu.sv
// ADS8685 SPI responder used in place of the real ADC on the loopback build.
//
// state    | meaning
// ST_IDLE  | waiting for CONVST/CS falling edge, SDO held low
// ST_SHIFT | frame in progress: sample SDI on SCLK rise, advance SDO on SCLK fall
// ST_EXEC  | one cycle after CS rises: latch sample, start RVS, decode command
module ads8685_emu
  import ads8685_pkg::*;
#(
  parameter int CONV_CYCLES = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  ads8685_if.slave    bus,
  input  logic [15:0] sample_data,
  output logic        sample_req,
  output logic [3:0]  range_sel,
  output logic        cmd_valid,
  output logic        frame_err
);

  localparam int            CW        = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [5:0]    CNT_FULL  = 6'(FRAME_BITS);
  localparam logic [5:0]    CNT_SAT   = 6'(FRAME_BITS + 1);

  logic csn_lvl, csn_rise, csn_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  ads_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk_ref), .rst_n(sys_rstn), .din(bus.convst_csn),
    .dout(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );

  ads_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk_ref), .rst_n(sys_rstn), .din(bus.ads_sclk),
    .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  ads_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk_ref), .rst_n(sys_rstn), .din(bus.ads_sdi),
    .dout(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  // Only the CS/SCLK strobes and the SDI level drive the protocol
  logic unused_sync;
  assign unused_sync = ^{csn_lvl, sclk_lvl, sdi_rise, sdi_fall};

  state_t        state;
  logic [31:0]   tx_shift;
  logic [31:0]   rx_shift;
  logic [5:0]    bit_cnt;
  logic          sdo_q;
  logic          rvs_q;
  logic [CW-1:0] conv_cnt;
  logic [15:0]   result_latch;
  logic [15:0]   readback_data;
  logic          readback_pending;
  logic [15:0]   reg_sdi_ctl;
  logic [15:0]   reg_sdo_ctl;
  logic [15:0]   reg_range;

  frame_t      rx_f;
  logic [15:0] rd_sel;
  logic [15:0] tx_hi;

  assign rx_f  = rx_shift;
  assign tx_hi = readback_pending ? readback_data : result_latch;

  // Register readback mux; unmapped addresses read as zero
  always_comb begin
    rd_sel = 16'h0000;
    case (rx_f.addr)
      ADDR_SDI_CTL: rd_sel = reg_sdi_ctl;
      ADDR_SDO_CTL: rd_sel = reg_sdo_ctl;
      ADDR_RANGE:   rd_sel = reg_range;
      default:      rd_sel = 16'h0000;
    endcase
  end

  // Frame FSM, RVS countdown, register file and pulse outputs
  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state            <= ST_IDLE;
      tx_shift         <= '0;
      rx_shift         <= '0;
      bit_cnt          <= '0;
      sdo_q            <= 1'b0;
      rvs_q            <= 1'b1;
      conv_cnt         <= '0;
      sample_req       <= 1'b0;
      cmd_valid        <= 1'b0;
      frame_err        <= 1'b0;
      result_latch     <= '0;
      readback_data    <= '0;
      readback_pending <= 1'b0;
      reg_sdi_ctl      <= '0;
      reg_sdo_ctl      <= '0;
      reg_range        <= '0;
    end else begin
      sample_req <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;

      // RVS stays low until the terminal count; an EXEC below reloads it
      if (!rvs_q) begin
        if (conv_cnt == '0) rvs_q    <= 1'b1;
        else                conv_cnt <= conv_cnt - CW'(1);
      end

      case (state)
        ST_IDLE: begin
          sdo_q <= 1'b0;
          // A new frame is accepted even while a conversion is still busy
          if (csn_fall) begin
            state    <= ST_SHIFT;
            tx_shift <= {tx_hi, 16'h0000};
            sdo_q    <= tx_hi[15];
            rx_shift <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_SHIFT: begin
          // CS rising takes priority over any SCLK edge in the same cycle
          if (csn_rise) begin
            state <= ST_EXEC;
            sdo_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[30:0], sdi_lvl};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            sdo_q    <= tx_shift[30];
          end
        end

        ST_EXEC: begin
          state            <= ST_IDLE;
          sdo_q            <= 1'b0;
          result_latch     <= sample_data;
          sample_req       <= 1'b1;
          readback_pending <= 1'b0;
          rvs_q            <= 1'b0;
          conv_cnt         <= CONV_LOAD;
          if (bit_cnt == CNT_FULL) begin
            cmd_valid <= 1'b1;
            case (rx_f.opcode)
              OP_WR_HW: begin
                case (rx_f.addr)
                  ADDR_SDI_CTL: reg_sdi_ctl <= rx_f.data;
                  ADDR_SDO_CTL: reg_sdo_ctl <= rx_f.data;
                  ADDR_RANGE:   reg_range   <= rx_f.data;
                  default: ;
                endcase
              end
              OP_RD_HW: begin
                readback_data    <= rd_sel;
                readback_pending <= 1'b1;
              end
              OP_RD_B: begin
                readback_data    <= {rd_sel[7:0], 8'h00};
                readback_pending <= 1'b1;
              end
              OP_NOP:  ;
              default: ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ads_sdo0 = sdo_q;
  assign bus.ads_rvs  = rvs_q;
  assign range_sel    = reg_range[3:0];

endmodule

// File: tb/tb_ads8685_emu.sv
// Directed plus randomized frames against a behavioural model of the ADS8685 responder.
module tb_ads8685_emu;

  localparam int HALF = 5;
  localparam int CONV = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample_data;
  logic        sample_req;
  logic [3:0]  range_sel;
  logic        cmd_valid;
  logic        frame_err;

  ads8685_if bus();

  ads8685_emu #(.CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
    .clk_ref    (clk),
    .sys_rstn   (rst_n),
    .bus        (bus),
    .sample_data(sample_data),
    .sample_req (sample_req),
    .range_sel  (range_sel),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse and RVS monitor, sampled 2 time units after each rising edge
  int cyc = 0, n_req = 0, n_cmd = 0, n_err = 0;
  int req_cyc = 0, rise_cyc = 0, low_len = 0, last_low = 0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (sample_req === 1'b1) begin n_req++; req_cyc = cyc; end
    if (cmd_valid === 1'b1) n_cmd++;
    if (frame_err === 1'b1) n_err++;
    if (bus.ads_rvs === 1'b0) low_len++;
    else if (low_len != 0) begin
      last_low = low_len;
      rise_cyc = cyc;
      low_len  = 0;
    end
  end

  // Behavioural model state
  logic [15:0] m_reg [int];
  logic [15:0] m_result;
  logic [15:0] m_rb;
  bit          m_pending;
  logic [8:0]  addr_list [4] = '{9'h00C, 9'h010, 9'h014, 9'h020};

  task automatic model_reset();
    m_reg.delete();
    m_reg[12] = 16'h0; m_reg[16] = 16'h0; m_reg[20] = 16'h0;
    m_result = 16'h0; m_rb = 16'h0; m_pending = 0;
  endtask

  function automatic logic [15:0] m_rd(input logic [8:0] a);
    if (m_reg.exists(int'(a))) return m_reg[int'(a)];
    return 16'h0;
  endfunction

  task automatic model_exec(input logic [31:0] w, input int nbits);
    logic [6:0]  op;
    logic [8:0]  a;
    logic [15:0] d, r;
    op = w[31:25]; a = w[24:16]; d = w[15:0];
    m_result  = sample_data;
    m_pending = 0;
    if (nbits == 32) begin
      r = m_rd(a);
      if (op == 7'b1101000) begin
        if (m_reg.exists(int'(a))) m_reg[int'(a)] = d;
      end else if (op == 7'b1100100) begin
        m_rb = r; m_pending = 1;
      end else if (op == 7'b0100100) begin
        m_rb = {r[7:0], 8'h00}; m_pending = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame of nbits SCLK periods; checks SDO data, pulses, range and RVS
  task automatic spi_frame(input logic [31:0] word, input int nbits, input bit wait_rvs,
                           input int exp_low, output logic [31:0] rd);
    logic [31:0] tx, exp;
    logic [15:0] r20;
    int req0, cmd0, err0;
    tx   = {(m_pending ? m_rb : m_result), 16'h0000};
    req0 = n_req; cmd0 = n_cmd; err0 = n_err;
    rd   = '0;
    bus.convst_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i < 32) bus.ads_sdi = word[31-i];
      else        bus.ads_sdi = 1'b0;
      wait_clk(HALF);
      rd = {rd[30:0], bus.ads_sdo0};
      bus.ads_sclk = 1'b1;
      wait_clk(HALF);
      bus.ads_sclk = 1'b0;
    end
    wait_clk(HALF);
    bus.convst_csn = 1'b1;
    bus.ads_sdi    = 1'b0;
    wait_clk(10);
    model_exec(word, nbits);
    if (nbits > 0) begin
      exp = (nbits == 33) ? {tx[30:0], 1'b0} : (tx >> (32 - nbits));
      check("sdo_data", rd, exp);
    end
    check("sample_req_cnt", 32'(n_req - req0), 32'd1);
    check("cmd_valid_cnt", 32'(n_cmd - cmd0), (nbits == 32) ? 32'd1 : 32'd0);
    check("frame_err_cnt", 32'(n_err - err0), (nbits != 32) ? 32'd1 : 32'd0);
    r20 = m_reg[20];
    check("range_sel", 32'(range_sel), 32'(r20[3:0]));
    check("rvs_busy", 32'(bus.ads_rvs), 32'd0);
    if (wait_rvs) begin
      for (int k = 0; k < 200 && bus.ads_rvs !== 1'b1; k++) wait_clk(1);
      check("rvs_return", 32'(bus.ads_rvs), 32'd1);
      wait_clk(1);
      check("rvs_gap", 32'(rise_cyc - req_cyc), 32'(CONV));
      if (exp_low > 0) check("rvs_len", 32'(last_low), 32'(exp_low));
    end
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog run_incomplete checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int req0, cmd0, err0;
    logic [31:0] w31;

    rst_n          = 1'b0;
    bus.convst_csn = 1'b1;
    bus.ads_sclk   = 1'b0;
    bus.ads_sdi    = 1'b0;
    sample_data    = 16'h0000;
    model_reset();
    wait_clk(4);
    check("rst_sdo0", 32'(bus.ads_sdo0), 32'd0);
    check("rst_rvs", 32'(bus.ads_rvs), 32'd1);
    check("rst_range", 32'(range_sel), 32'd0);
    check("rst_pulses", 32'({sample_req, cmd_valid, frame_err}), 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Two NOPs: the second returns the conversion latched by the first
    sample_data = 16'h1234;
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("nop1_result", 32'(rd[31:16]), 32'h0000);
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("nop2_result", 32'(rd[31:16]), 32'h1234);

    // Writes and halfword readback
    spi_frame(32'hD010_0055, 32, 1, CONV, rd);
    spi_frame(32'hD014_0001, 32, 1, CONV, rd);
    check("range_after_wr", 32'(range_sel), 32'h1);
    spi_frame(32'hC810_0000, 32, 1, CONV, rd);
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("hw_readback", 32'(rd[31:16]), 32'h0055);
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("result_resumes", 32'(rd[31:16]), 32'h1234);

    // Byte readback
    spi_frame(32'hD014_00A7, 32, 1, CONV, rd);
    spi_frame(32'h4814_0000, 32, 1, CONV, rd);
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("byte_readback", 32'(rd[31:16]), 32'hA700);

    // 31-bit frame: error pulse, no write, normal conversion timing
    spi_frame(32'hD014_000F, 31, 1, CONV, rd);
    check("short_no_write", 32'(range_sel), 32'h7);

    // Back-to-back frames while RVS is still low restart the countdown
    spi_frame(32'h0000_0000, 32, 0, 0, rd);
    spi_frame(32'h0000_0000, 0, 1, 0, rd);
    check("rvs_restart_ext", 32'(last_low > CONV), 32'd1);

    // Reset in the middle of a write to the range register
    sample_data = 16'hBEEF;
    req0 = n_req; cmd0 = n_cmd; err0 = n_err;
    w31 = 32'hD014_0003;
    bus.convst_csn = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) begin
      bus.ads_sdi = w31[31-i];
      wait_clk(HALF);
      bus.ads_sclk = 1'b1;
      wait_clk(HALF);
      bus.ads_sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_sdo0", 32'(bus.ads_sdo0), 32'd0);
    check("midrst_rvs", 32'(bus.ads_rvs), 32'd1);
    check("midrst_range", 32'(range_sel), 32'd0);
    bus.convst_csn = 1'b1;
    bus.ads_sdi    = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(12);
    check("midrst_no_pulses", 32'((n_req - req0) + (n_cmd - cmd0) + (n_err - err0)), 32'd0);
    model_reset();
    spi_frame(32'h0000_0000, 32, 1, CONV, rd);
    check("midrst_result", 32'(rd[31:16]), 32'h0000);

    // Randomized command mix, including occasional 31/33-bit frames
    for (int n = 0; n < 40; n++) begin
      int          kind, nb;
      logic [8:0]  a;
      logic [31:0] w;
      sample_data = 16'($urandom);
      kind = $urandom_range(0, 5);
      a    = addr_list[$urandom_range(0, 3)];
      case (kind)
        0, 5:    w = {7'b1101000, a, 16'($urandom)};
        1:       w = {7'b1100100, a, 16'h0000};
        2:       w = {7'b0100100, a, 16'h0000};
        3:       w = 32'h0000_0000;
        default: w = $urandom;
      endcase
      nb = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 31 : 33) : 32;
      spi_frame(w, nb, 1, CONV, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ads8685_emu.md
Name: ads8685_emu

Overview:
- Synthesizable ADS8685 SPI responder; the device side of the ADC serial interface our ADC controller drives.
- Sits on the FPGA loopback/test build in place of the real ADC.
- Decodes 32-bit command frames on SDI, holds the ADC config registers, and returns conversion or readback data on SDO0.
- Drives RVS so the controller can be verified without hardware.

Parameters:
- CONV_CYCLES, 20: clk_ref cycles that RVS stays low after a conversion start.
- SYNC_STAGES, 2: synchronizer depth on convst_csn, ads_sclk and ads_sdi.

Ports:
- clk_ref  in  1  emulator clock; must be at least 4x the SCLK frequency.
- sys_rstn  in  1  async active-low reset.
- convst_csn  in  1  CONVST/CS from the controller.
- ads_sclk  in  1  SPI clock.
- ads_sdi  in  1  command data, MSB first.
- ads_sdo0  out  1  response data, MSB first.
- ads_rvs  out  1  ready/busy indicator.
- sample_data  in  16  conversion value to return.
- sample_req  out  1  1-cycle pulse when sample_data is latched.
- range_sel  out  4  reg 0x14 bits [3:0].
- cmd_valid  out  1  1-cycle pulse when a well-formed frame executes.
- frame_err  out  1  1-cycle pulse when a frame ends without exactly 32 SCLK rises.

Behaviour:
- Clock and reset: one clock, clk_ref. Reset sys_rstn is asynchronous, active-low.
- Reset values:
  - ads_sdo0=0, ads_rvs=1, sample_req=0, cmd_valid=0, frame_err=0, range_sel=0.
  - Registers 0x0C, 0x10, 0x14 = 0. Result latch = 0. readback_pending=0.
- Input synchronization: all three inputs pass through SYNC_STAGES flops. Edges are detected on the synced versions, one cycle after sync.
- FSM states:
  - IDLE → SHIFT on synced csn falling edge. In the same cycle, load tx_shift with a 32-bit word:
    - upper 16 bits = readback_pending ? readback_data : result_latch;
    - lower 16 bits = 0.
    - ads_sdo0 = tx_shift[31] from that cycle on.
  - SHIFT, on SCLK rise: rx_shift <= {rx_shift[30:0], sdi}; bit_cnt increments and saturates at 33.
  - SHIFT, on SCLK fall: tx_shift shifts left and ads_sdo0 presents the next bit. After 32 bits, shift in 0.
  - SHIFT → EXEC on synced csn rising edge.
  - EXEC lasts one cycle, then → IDLE. ads_sdo0=0 whenever not in SHIFT.
- EXEC actions, always:
  - result_latch <= sample_data; sample_req pulses.
  - readback_pending is cleared.
  - ads_rvs <= 0 and a counter starts. ads_rvs returns to 1 after CONV_CYCLES cycles.
- EXEC actions, only when bit_cnt==32 (cmd_valid pulses; fields opcode=rx[31:25], addr=rx[24:16], data=rx[15:0]):
  - opcode 7'b1101000, halfword write: if addr is 0x0C, 0x10 or 0x14, that register <= data. Other addresses are ignored.
  - opcode 7'b1100100, halfword read: readback_data <= register at addr (unmapped reads 0); readback_pending <= 1. The next frame returns it instead of the conversion result, then normal results resume.
  - opcode 7'b0100100, byte read: as halfword read, but readback_data = {reg[7:0], 8'h00}.
  - all-zero word: NOP.
  - any other opcode: ignored, but cmd_valid still pulses.
- EXEC with bit_cnt≠32: frame_err pulses, no register effect. Conversion and RVS behave as normal.
- Simultaneous events:
  - csn rising edge and SCLK edge in the same cycle: csn wins and the SCLK edge is dropped.
  - csn falling edge while RVS is low: accepted; the RVS countdown continues.
  - New EXEC while RVS is low: the RVS counter restarts.
- Reset mid-frame: immediate return to IDLE with all reset values. The frame is lost; no pulses are generated.

Decomposition:
- Package ads8685_pkg:
  - opcode constants: OP_WR_HW, OP_RD_HW, OP_RD_B, OP_NOP;
  - register addresses: ADDR_SDI_CTL=0x0C, ADDR_SDO_CTL=0x10, ADDR_RANGE=0x14;
  - FSM state encoding; FRAME_BITS=32.
- One sub-module, ads_sync_edge: an N-stage synchronizer with rise/fall strobes, instantiated once per input.

Test Plan:
- sample_data=16'h1234, two NOP frames → second frame's first 16 SDO bits = 16'h1234; sample_req pulses at each csn rise; cmd_valid pulses twice.
- Frame D0140001, then C8100000 preceded by D0100055 → range_sel=4'h1; the frame after C8100000 returns 16'h0055 in bits [31:16]; the following frame returns the conversion result again.
- Frame 48140000 after D01400A7 → next frame returns 16'hA700.
- 31-bit frame D014000F → frame_err pulses, range_sel unchanged, RVS still low for exactly CONV_CYCLES=20 cycles.
- Assert sys_rstn low after 10 bits of D0140003 → ads_sdo0=0, ads_rvs=1, range_sel=0; the next full NOP frame returns 16'h0000.
- Closed loop against the ADC controller with clk_ref at 8x SCLK → controller dout = sample_data on every frame after the config sequence, and register 0x10 readback = last written value.
